decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  Registered, parametrised decode stage for the ALU instruction class: accepts raw instructions
//  over a valid/ready handshake, decodes them into ALU control fields and holds them in a
//  2-entry skid buffer feeding the execute stage. Adds illegal-opcode detection, sign/zero-
//  extended immediates, flush, and a saturating illegal-instruction counter.
// PARAMETERS
//  REG_BITS    3   register index width; INSTR_W = 3*REG_BITS+7 (16 at default)
//  DATA_W      16  width of out_immv
//  IMM_SIGNED  0   1: sign-extend immediate field, 0: zero-extend
//  CNT_W       8   width of illegal_cnt
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  flush        in   1         synchronous pipeline flush
//  in_valid     in   1         in_instr valid
//  in_ready     out  1         stage can accept an instruction this cycle
//  in_instr     in   INSTR_W   raw instruction
//  out_valid    out  1         decoded entry valid at head
//  out_ready    in   1         execute stage accepts head entry
//  out_unary    out  1         single-operand op (MOV/MOVI)
//  out_imm      out  1         operand B is out_immv
//  out_aluop    out  4         ALU opcode
//  out_setcc    out  1         update condition codes
//  out_rd/ra/rb out  REG_BITS  destination / source A / source B
//  out_immv     out  DATA_W    extended immediate
//  out_wben     out  1         register write enable
//  out_illegal  out  1         head entry is an illegal instruction
//  illegal_cnt  out  CNT_W     illegal instructions delivered since reset
// BEHAVIOUR
//  - Fields (R=REG_BITS, W=INSTR_W): op=[W-1:W-4], immbit=[W-5], setcc=[W-6], rd=[3R:2R+1],
//    ra=[2R:R+1], rb=[R:1], immfield=[R:0]. Decode key = {op,immbit} (5 bits).
//  - Key->aluop: 0000x ADD 0001; 0001x MOV (ADD, unary=1); 0010x SUB 0010; 0011x SHL 0101;
//    0100x SHAR 0110; 0101x SHLR 0111; 0110x RL 1000; 0111x RR 1001; 1000x AND 1011;
//    1001x OR 1100; 10110 NOT 1110; 1100x MULT 1111. All other keys illegal.
//  - Legal: wben=1, setcc=instr bit; immbit=1 -> imm=1, rb=0, immv=ext(immfield);
//    immbit=0 -> imm=0, rb=field, immv=0. No X ever driven.
//  - Illegal: illegal=1, wben=0, setcc=0, aluop=0000, unary/imm/rd/ra/rb/immv=0.
//  - Decode happens on push; buffer stores decoded fields. Push when in_valid&in_ready;
//    pop when out_valid&out_ready. Latency 1: pushed at edge N, visible at head after N.
//  - in_ready = (count<2), registered from count; out_valid = (count>0). Full throughput
//    1/cycle with continuous out_ready. Push+pop same cycle: count unchanged, order kept.
//  - count=2 and pop: in_ready rises next cycle (no same-cycle bypass). count=0: outputs
//    hold zero values, out_valid=0.
//  - flush: next edge count=0, out_valid=0, in_ready=1; any push/pop that cycle discarded;
//    illegal_cnt not incremented by discarded entries.
//  - illegal_cnt increments on pop of an illegal entry, saturates at all-ones.
//  - Reset (async, any time incl. mid-transfer): count=0, entries cleared, out_valid=0,
//    in_ready=1, all decoded outputs 0, illegal_cnt=0.
// TESTING
//  - ADD: in 0x04A6, out_ready=1 -> next cycle out_valid=1, aluop=0001, setcc=1, rd=1, ra=2,
//    rb=3, imm=0, wben=1, illegal=0.
//  - ADDI 0x08AF with IMM_SIGNED=1 -> imm=1, rb=0, immv=0xFFFF; IMM_SIGNED=0 -> immv=0x000F.
//  - Illegal 0xA000 and NOT-imm 0xB800 -> illegal=1, wben=0, aluop=0000; illegal_cnt 0->2
//    after both pop; CNT_W=2 with 5 illegals -> holds 3.
//  - Backpressure: out_ready=0, push 3 back-to-back -> in_ready low after 2nd; release ->
//    entries emerge in order, in_ready=1 one cycle after first pop.
//  - Flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, counter unchanged.
//  - Assert rst_n=0 mid-stream -> outputs zero immediately, no stale entry after release.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage for the ALU instruction class: decodes raw instructions on push and
// holds the decoded control fields in a 2-entry skid buffer feeding the execute stage.
module decode_stage_pipe #(
  parameter int REG_BITS   = 3,
  parameter int DATA_W     = 16,
  parameter int IMM_SIGNED = 0,
  parameter int CNT_W      = 8,
  localparam int INSTR_W   = 3*REG_BITS+7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_unary,
  output logic                out_imm,
  output logic [3:0]          out_aluop,
  output logic                out_setcc,
  output logic [REG_BITS-1:0] out_rd,
  output logic [REG_BITS-1:0] out_ra,
  output logic [REG_BITS-1:0] out_rb,
  output logic [DATA_W-1:0]   out_immv,
  output logic                out_wben,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    illegal_cnt
);

  typedef struct packed {
    logic                unary;
    logic                imm;
    logic [3:0]          aluop;
    logic                setcc;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] ra;
    logic [REG_BITS-1:0] rb;
    logic [DATA_W-1:0]   immv;
    logic                wben;
    logic                illegal;
  } entry_t;

  localparam logic [DATA_W-1:0] EXT_MASK = {DATA_W{1'b1}} << (REG_BITS+1);

  logic [4:0]          key;
  logic [REG_BITS:0]   imm_field;
  logic [DATA_W-1:0]   imm_ext;
  entry_t              dec;
  entry_t              mem [2];
  entry_t              head;
  logic [1:0]          count;
  logic [1:0]          count_next;
  logic                wr_ptr;
  logic                rd_ptr;
  logic                push;
  logic                pop;

  assign key       = {in_instr[INSTR_W-1 -: 4], in_instr[INSTR_W-5]};
  assign imm_field = in_instr[REG_BITS:0];
  assign imm_ext   = DATA_W'(imm_field) |
                     (((IMM_SIGNED != 0) && imm_field[REG_BITS]) ? EXT_MASK : '0);

  always_comb begin
    dec = '0;
    casez (key)
      5'b0000?: dec.aluop = 4'b0001;
      5'b0001?: begin dec.aluop = 4'b0001; dec.unary = 1'b1; end
      5'b0010?: dec.aluop = 4'b0010;
      5'b0011?: dec.aluop = 4'b0101;
      5'b0100?: dec.aluop = 4'b0110;
      5'b0101?: dec.aluop = 4'b0111;
      5'b0110?: dec.aluop = 4'b1000;
      5'b0111?: dec.aluop = 4'b1001;
      5'b1000?: dec.aluop = 4'b1011;
      5'b1001?: dec.aluop = 4'b1100;
      5'b10110: dec.aluop = 4'b1110;
      5'b1100?: dec.aluop = 4'b1111;
      default:  dec.illegal = 1'b1;
    endcase
    // Illegal entries keep every field except the illegal flag at zero.
    if (!dec.illegal) begin
      dec.wben  = 1'b1;
      dec.setcc = in_instr[INSTR_W-6];
      dec.rd    = in_instr[3*REG_BITS -: REG_BITS];
      dec.ra    = in_instr[2*REG_BITS -: REG_BITS];
      if (key[0]) begin
        dec.imm  = 1'b1;
        dec.immv = imm_ext;
      end else begin
        dec.rb = in_instr[REG_BITS:1];
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      in_ready    <= 1'b1;
      illegal_cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (mem[rd_ptr].illegal && (illegal_cnt != {CNT_W{1'b1}}))
          illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
    end
  end

  // An empty buffer presents all-zero decoded fields.
  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_unary   = head.unary;
  assign out_imm     = head.imm;
  assign out_aluop   = head.aluop;
  assign out_setcc   = head.setcc;
  assign out_rd      = head.rd;
  assign out_ra      = head.ra;
  assign out_rb      = head.rb;
  assign out_immv    = head.immv;
  assign out_wben    = head.wben;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: two instances (zero-extend/CNT_W=8 and sign-extend/CNT_W=2)
// share stimulus and are compared every cycle against a queue-based reference model.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_unary, a_imm, a_setcc, a_wben, a_illegal;
  logic [3:0]  a_aluop;
  logic [2:0]  a_rd, a_ra, a_rb;
  logic [15:0] a_immv;
  logic [7:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_unary, b_imm, b_setcc, b_wben, b_illegal;
  logic [3:0]  b_aluop;
  logic [2:0]  b_rd, b_ra, b_rb;
  logic [15:0] b_immv;
  logic [1:0]  b_cnt;

  typedef struct packed {
    logic       unary;
    logic       imm;
    logic [3:0] aluop;
    logic       setcc;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [15:0] immv;
    logic       wben;
    logic       illegal;
  } exp_t;

  logic [15:0] q [$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  int          checks = 0;
  int          failures = 0;
  bit          m_push, m_pop;

  always #5 clk = ~clk;

  decode_stage_pipe #(.REG_BITS(3), .DATA_W(16), .IMM_SIGNED(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready), .out_unary(a_unary),
    .out_imm(a_imm), .out_aluop(a_aluop), .out_setcc(a_setcc), .out_rd(a_rd), .out_ra(a_ra),
    .out_rb(a_rb), .out_immv(a_immv), .out_wben(a_wben), .out_illegal(a_illegal),
    .illegal_cnt(a_cnt));

  decode_stage_pipe #(.REG_BITS(3), .DATA_W(16), .IMM_SIGNED(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready), .out_unary(b_unary),
    .out_imm(b_imm), .out_aluop(b_aluop), .out_setcc(b_setcc), .out_rd(b_rd), .out_ra(b_ra),
    .out_rb(b_rb), .out_immv(b_immv), .out_wben(b_wben), .out_illegal(b_illegal),
    .illegal_cnt(b_cnt));

  function automatic logic [3:0] alu_code(input int op);
    case (op)
      0, 1:    return 4'h1;
      2:       return 4'h2;
      3:       return 4'h5;
      4:       return 4'h6;
      5:       return 4'h7;
      6:       return 4'h8;
      7:       return 4'h9;
      8:       return 4'hB;
      9:       return 4'hC;
      11:      return 4'hE;
      12:      return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] ins, input bit sgn);
    exp_t e;
    int   op;
    int   f;
    bit   ib;
    e  = '0;
    op = int'(ins[15:12]);
    ib = ins[11];
    if (!(op <= 9 || (op == 11 && !ib) || op == 12)) begin
      e.illegal = 1'b1;
      return e;
    end
    e.aluop = alu_code(op);
    e.unary = (op == 1);
    e.wben  = 1'b1;
    e.setcc = ins[10];
    e.rd    = ins[9:7];
    e.ra    = ins[6:4];
    if (ib) begin
      e.imm = 1'b1;
      f = int'(ins[3:0]);
      if (sgn && f >= 8) f = f - 16;
      e.immv = 16'(f);
    end else begin
      e.rb = ins[3:1];
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareOne(input string p, input bit sgn, input int cnt_exp,
                            input logic v, input logic r, input logic unary, input logic imm,
                            input logic [3:0] aluop, input logic setcc, input logic [2:0] rd,
                            input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] immv,
                            input logic wben, input logic illegal, input logic [7:0] cnt);
    exp_t e;
    e = (q.size() > 0) ? model(q[0], sgn) : '0;
    checkOutput({p, "_valid"}, 32'(v), 32'(q.size() > 0));
    checkOutput({p, "_ready"}, 32'(r), 32'(q.size() < 2));
    checkOutput({p, "_aluop"}, 32'(aluop), 32'(e.aluop));
    checkOutput({p, "_ctrl"}, 32'({unary, imm, setcc, wben, illegal}),
                32'({e.unary, e.imm, e.setcc, e.wben, e.illegal}));
    checkOutput({p, "_regs"}, 32'({rd, ra, rb}), 32'({e.rd, e.ra, e.rb}));
    checkOutput({p, "_immv"}, 32'(immv), 32'(e.immv));
    checkOutput({p, "_cnt"}, 32'(cnt), 32'(cnt_exp));
  endtask

  task automatic compareAll();
    compareOne("a", 1'b0, cnt_a, a_out_valid, a_in_ready, a_unary, a_imm, a_aluop, a_setcc,
               a_rd, a_ra, a_rb, a_immv, a_wben, a_illegal, a_cnt);
    compareOne("b", 1'b1, cnt_b, b_out_valid, b_in_ready, b_unary, b_imm, b_aluop, b_setcc,
               b_rd, b_ra, b_rb, b_immv, b_wben, b_illegal, 8'(b_cnt));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic rdy,
                               input logic fl);
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    m_push = v && (q.size() < 2);
    m_pop  = rdy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (m_pop) begin
        if (model(q[0], 1'b0).illegal) begin
          if (cnt_a < 255) cnt_a++;
          if (cnt_b < 3) cnt_b++;
        end
        void'(q.pop_front());
      end
      if (m_push) q.push_back(ins);
    end
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    int saved_cnt;
    repeat (2) @(negedge clk);
    compareAll();
    rst_n = 1'b1;

    applyStimulus(1'b1, 16'h04A6, 1'b1, 1'b0);
    checkOutput("add_aluop", 32'(a_aluop), 32'h1);
    checkOutput("add_fields", 32'({a_setcc, a_rd, a_ra, a_rb, a_imm, a_wben, a_illegal}),
                32'({1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0}));

    applyStimulus(1'b1, 16'h08AF, 1'b1, 1'b0);
    checkOutput("addi_zext", 32'(a_immv), 32'h000F);
    checkOutput("addi_sext", 32'(b_immv), 32'hFFFF);
    checkOutput("addi_imm_rb", 32'({b_imm, b_rb}), 32'({1'b1, 3'd0}));

    applyStimulus(1'b1, 16'hA000, 1'b1, 1'b0);
    checkOutput("ill_flags", 32'({a_illegal, a_wben, a_aluop}), 32'({1'b1, 1'b0, 4'h0}));
    applyStimulus(1'b1, 16'hB800, 1'b1, 1'b0);
    checkOutput("notimm_ill", 32'(a_illegal), 32'h1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("ill_cnt2", 32'(a_cnt), 32'd2);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'hA000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("cnt_a5", 32'(a_cnt), 32'd5);
    checkOutput("cnt_b_sat", 32'(b_cnt), 32'd3);

    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    checkOutput("bp_one", 32'(a_in_ready), 32'h1);
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
    checkOutput("bp_full", 32'(a_in_ready), 32'h0);
    applyStimulus(1'b1, 16'h4444, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
    checkOutput("bp_release", 32'(a_in_ready), 32'h1);
    applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'hA000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hA000, 1'b0, 1'b0);
    saved_cnt = cnt_a;
    applyStimulus(1'b1, 16'hA000, 1'b1, 1'b1);
    checkOutput("flush_state", 32'({a_out_valid, a_in_ready}), 32'({1'b0, 1'b1}));
    checkOutput("flush_cnt", 32'(a_cnt), 32'(saved_cnt));

    for (int i = 0; i < 2000; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));

    applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1C55, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    #1 compareAll();
    @(negedge clk);
    compareAll();
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
